// File: rtl/seq_cla_divider_pkg.sv
// Shared definitions for the sequential CLA divider: FSM encodings and CLA group size.
package seq_cla_divider_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned CLA_GROUP = 4;

endpackage

// File: rtl/seq_cla_divider_cla_subtractor.sv
// Combinational a - b computed as a + ~b + 1 with 4-bit carry-lookahead groups.
module cla_subtractor
  import seq_cla_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);

  localparam int unsigned NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] bn;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;

  always_comb begin
    bn    = ~b;
    g     = a & bn;
    p     = a ^ bn;
    c     = '0;
    gg    = '0;
    gp    = '0;
    gc    = '0;
    // The +1 of two's-complement negation enters as the carry into group 0.
    gc[0] = 1'b1;
    for (int unsigned j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    c[WIDTH] = gc[NG];
    diff     = p ^ c[WIDTH-1:0];
    cout     = c[WIDTH];
  end

endmodule

// File: rtl/seq_cla_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
module seq_cla_divider
  import seq_cla_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] r_q,      r_d;
  logic [WIDTH-1:0] q_q,      q_d;
  logic [WIDTH-1:0] dvs_q,    dvs_d;
  logic [WIDTH-1:0] quot_q,   quot_d;
  logic [WIDTH-1:0] rem_q,    rem_d;
  logic             dz_q,     dz_d;

  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] diff;
  logic             msb;
  logic             cout;
  logic             ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Shift the next dividend bit into the partial remainder; the bit shifted out is kept as msb.
  assign msb = r_q[WIDTH-1];
  assign rs  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  cla_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a    (rs),
    .b    (dvs_q),
    .diff (diff),
    .cout (cout)
  );

  assign ge     = msb | cout;
  assign r_next = ge ? diff : rs;
  assign q_next = {q_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    if (state_q == S_RUN) begin
      r_d   = r_next;
      q_d   = q_next;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = S_DONE;
        quot_d  = q_next;
        rem_d   = r_next;
      end
    end else begin
      state_d = S_IDLE;
      if (start) begin
        dvs_d = divisor;
        r_d   = '0;
        q_d   = dividend;
        cnt_d = '0;
        dz_d  = 1'b0;
        if (divisor == '0) begin
          state_d = S_DONE;
          quot_d  = '1;
          rem_d   = dividend;
          dz_d    = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_cla_divider.sv
// Scoreboard bench for seq_cla_divider (WIDTH=8) driven by hand-computed directed vectors.
module tb_seq_cla_divider;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  int   lat;
  int   seen_before;

  seq_cla_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", 32'(quotient), 32'(mon_e.q));
        check("remainder", 32'(remainder), 32'(mon_e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
      end
    end
  end

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dz = dz;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dz, input int exp_lat);
    int n;
    push(q, r, dz);
    issue(a, b);
    wait_done(n);
    check("latency", 32'(n), 32'(exp_lat));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_quotient", 32'(quotient), 0);
    check("reset_remainder", 32'(remainder), 0);
    check("reset_dz", 32'(div_by_zero), 0);

    // 100/7 with busy trace: busy for 8 cycles, then a single-cycle done.
    push(8'd14, 8'd2, 1'b0);
    issue(8'd100, 8'd7);
    for (int i = 0; i < 8; i++) begin
      check("busy_run", 32'(busy), 1);
      check("done_early", 32'(done), 0);
      @(negedge clk);
    end
    check("done_after_8", 32'(done), 1);
    check("busy_in_done", 32'(busy), 0);
    @(negedge clk);
    check("done_pulse_end", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);

    run_vec(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8);
    run_vec(8'd3,   8'd200, 8'd0,   8'd3,   1'b0, 8);
    run_vec(8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 8);
    run_vec(8'd0,   8'd9,   8'd0,   8'd0,   1'b0, 8);
    run_vec(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 8);
    run_vec(8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 8);
    run_vec(8'd5,   8'd0,   8'd255, 8'd5,   1'b1, 0);
    run_vec(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8);

    // start pulsed mid-RUN must be ignored.
    push(8'd14, 8'd2, 1'b0);
    issue(8'd100, 8'd7);
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ignored_start_latency", 32'(lat), 6);

    // start held high: second operation accepted straight from DONE.
    @(negedge clk);
    push(8'd4, 8'd1, 1'b0);
    start = 1'b1;
    dividend = 8'd17;
    divisor = 8'd4;
    @(negedge clk);
    wait_done(lat);
    check("b2b_first_latency", 32'(lat), 8);
    push(8'd4, 8'd2, 1'b0);
    dividend = 8'd18;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap", 32'(busy), 1);
    wait_done(lat);
    check("b2b_second_latency", 32'(lat), 8);

    // Reset during RUN aborts without a done pulse and clears the held results.
    issue(8'd100, 8'd7);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_before = done_seen;
    check("abort_busy", 32'(busy), 0);
    check("abort_quotient", 32'(quotient), 0);
    check("abort_remainder", 32'(remainder), 0);
    check("abort_dz", 32'(div_by_zero), 0);
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_seen), 32'(seen_before));
    run_vec(8'd42, 8'd5, 8'd8, 8'd2, 1'b0, 8);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
